// File: rtl/imu_filter_sequencer.sv
// imu_filter_sequencer
//   Paces periodic IMU accelerometer reads and feeds each new sample into a
//   low-pass filter, publishing the filtered result once the filter is warm.
//
//   Ports
//     Clock        in   system clock, rising edge
//     Reset_n      in   asynchronous active-low reset (release synchronised)
//     Enable       in   level, 1 = periodic sampling, 0 = stop after current sample
//     ReadReq      out  one-cycle pulse requesting an accelerometer read
//     ReadDone     in   one-cycle pulse, new accelerometer data valid
//     FilterStrobe out  one-cycle pulse clocking one sample into the filter
//     FilterReady  in   filter output valid
//     OutValid     out  one-cycle pulse, filtered data current and filter warm
//     Warm         out  level, FILTER_LEN samples strobed since reset
//     SampleCount  out  16-bit wrapping count of strobed samples
//     Fault        out  sticky read-timeout flag
//
//   Build option
//     IMU_SEQ_WATCHDOG_EN  defined: WAIT_READ abandons the read after
//                          READ_TIMEOUT cycles and sets Fault.
//                          undefined: WAIT_READ waits forever, Fault = 0.
module imu_filter_sequencer #(
  parameter int unsigned SAMPLE_DIV   = 250000,
  parameter int unsigned FILTER_LEN   = 200,
  parameter int unsigned READ_TIMEOUT = 4096
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Enable,
  output logic        ReadReq,
  input  logic        ReadDone,
  output logic        FilterStrobe,
  input  logic        FilterReady,
  output logic        OutValid,
  output logic        Warm,
  output logic [15:0] SampleCount,
  output logic        Fault
);

  localparam int unsigned DIV_W  = $clog2(SAMPLE_DIV);
  localparam int unsigned WARM_W = ($clog2(FILTER_LEN + 1) > 8) ? $clog2(FILTER_LEN + 1) : 8;
  localparam logic [DIV_W-1:0]  DIV_LOAD = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [WARM_W-1:0] WARM_TOP = WARM_W'(FILTER_LEN);

  if (SAMPLE_DIV < 16 || SAMPLE_DIV > 24'hFFFFFF || FILTER_LEN < 1 || READ_TIMEOUT < 2) begin : g_bad_params
    $error("imu_filter_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    REQUEST,
    WAIT_READ,
    STROBE,
    WAIT_FILT,
    PUBLISH
  } state_t;

  state_t             state, state_nx;
  logic [1:0]         rst_sync;
  logic               run_ok;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic               filt_armed;
  logic [WARM_W-1:0]  warm_cnt;
  logic               timeout;

  // Assertion is asynchronous everywhere; the FSM may only leave IDLE once
  // the release has passed through two flops.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign run_ok = rst_sync[1];

  // Sample period counter; the period is referenced to reset release so the
  // first request lands SAMPLE_DIV cycles after it.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)             div_cnt <= DIV_LOAD;
    else if (!Enable)         div_cnt <= DIV_LOAD;
    else if (div_cnt == '0)   div_cnt <= DIV_LOAD;
    else                      div_cnt <= div_cnt - 1'b1;
  end
  // A tick seen outside WAIT_TICK is an overrun and simply falls away.
  assign tick = Enable && (div_cnt == '0);

  // High from the second WAIT_FILT cycle on, so a FilterReady level left over
  // from the previous sample is not mistaken for the new result.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) filt_armed <= 1'b0;
    else          filt_armed <= (state == WAIT_FILT);
  end

`ifdef IMU_SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(READ_TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)                wd_cnt <= '0;
    else if (state == WAIT_READ) wd_cnt <= wd_cnt + 1'b1;
    else                         wd_cnt <= '0;
  end

  // REQUEST plus READ_TIMEOUT-1 WAIT_READ cycles without ReadDone.
  assign timeout = (state == WAIT_READ) && !ReadDone && (wd_cnt == WD_W'(READ_TIMEOUT - 2));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)     Fault <= 1'b0;
    else if (timeout) Fault <= 1'b1;
  end
`else
  assign timeout = 1'b0;
  assign Fault   = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (Enable && run_ok) state_nx = WAIT_TICK;
      WAIT_TICK: begin
        if (!Enable)   state_nx = IDLE;
        else if (tick) state_nx = REQUEST;
      end
      REQUEST:   state_nx = WAIT_READ;
      WAIT_READ: begin
        if (ReadDone)     state_nx = STROBE;
        else if (timeout) state_nx = WAIT_TICK;
      end
      STROBE:    state_nx = WAIT_FILT;
      WAIT_FILT: if (filt_armed && FilterReady) state_nx = PUBLISH;
      PUBLISH:   state_nx = Enable ? WAIT_TICK : IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      SampleCount <= '0;
      warm_cnt    <= '0;
    end else if (state == STROBE) begin
      SampleCount <= SampleCount + 16'd1;
      if (warm_cnt != WARM_TOP) warm_cnt <= warm_cnt + 1'b1;
    end
  end

  assign Warm         = (warm_cnt == WARM_TOP);
  assign ReadReq      = (state == REQUEST);
  assign FilterStrobe = (state == STROBE);
  assign OutValid     = (state == PUBLISH) && Warm;

endmodule

// File: tb/tb_imu_filter_sequencer.sv
module tb_imu_filter_sequencer;

  localparam int unsigned SDIV = 16;
  localparam int unsigned FLEN = 4;
  localparam int unsigned RTO  = 8;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Enable;
  logic        ReadReq;
  logic        ReadDone;
  logic        FilterStrobe;
  logic        FilterReady;
  logic        OutValid;
  logic        Warm;
  logic [15:0] SampleCount;
  logic        Fault;

  imu_filter_sequencer #(
    .SAMPLE_DIV  (SDIV),
    .FILTER_LEN  (FLEN),
    .READ_TIMEOUT(RTO)
  ) dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .Enable      (Enable),
    .ReadReq     (ReadReq),
    .ReadDone    (ReadDone),
    .FilterStrobe(FilterStrobe),
    .FilterReady (FilterReady),
    .OutValid    (OutValid),
    .Warm        (Warm),
    .SampleCount (SampleCount),
    .Fault       (Fault)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc++;

  int vec_n  = 0;
  int miss_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard entry: what the DUT must show after a strobe.
  typedef struct {
    int cnt;
    bit warm;
    bit ov;
    int gap;
  } exp_t;
  exp_t sb[$];

  bit   prev_done  = 1'b0;
  bit   cnt_pend   = 1'b0;
  bit   ov_armed   = 1'b0;
  int   strobe_cyc = 0;
  int   ov_count   = 0;
  int   req_count  = 0;
  exp_t cur;

  always @(negedge Clock) begin
    if (FilterStrobe === 1'b1) begin
      check("strobe_latency", prev_done, 1);
      check("strobe_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        cur        = sb.pop_front();
        cnt_pend   = 1'b1;
        ov_armed   = cur.ov;
        strobe_cyc = cyc;
      end
    end else if (cnt_pend) begin
      check("sample_count", SampleCount, cur.cnt);
      check("warm", Warm, cur.warm);
      cnt_pend = 1'b0;
    end
    if (OutValid === 1'b1) begin
      check("outvalid_expected", ov_armed, 1);
      check("publish_gap", cyc - strobe_cyc, cur.gap);
      ov_armed = 1'b0;
      ov_count++;
    end
    if (ReadReq === 1'b1) req_count++;
    prev_done = ReadDone;
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_req(output int rc);
    rc = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (ReadReq === 1'b1) begin
        rc = cyc;
        break;
      end
    end
    check("req_seen", rc >= 0, 1);
  endtask

  // Answer a read dd cycles after ReadReq. fd == 0 keeps FilterReady high;
  // otherwise it stays high (stale) for two cycles, drops, and returns fd
  // cycles after the strobe.
  task automatic serve(input int dd, input int fd, input int cnt, input bit warm, input bit ov);
    exp_t e;
    repeat (dd) step();
    e.cnt  = cnt;
    e.warm = warm;
    e.ov   = ov;
    e.gap  = (fd == 0) ? 3 : fd + 1;
    sb.push_back(e);
    ReadDone    = 1'b1;
    FilterReady = 1'b1;
    step();
    ReadDone = 1'b0;
    check("strobe_now", FilterStrobe, 1);
    if (fd > 0) begin
      step();
      step();
      FilterReady = 1'b0;
      repeat (fd - 2) step();
      FilterReady = 1'b1;
    end
    repeat (4) step();
  endtask

  typedef struct {
    int dd;
    int fd;
    int cnt;
    bit warm;
    bit ov;
  } vec_t;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[6];
    int   rc, last, rel, ov_total, exp_cnt, req_snap, ov_snap;

    tbl[0] = '{dd: 3, fd: 0, cnt: 1, warm: 1'b0, ov: 1'b0};
    tbl[1] = '{dd: 1, fd: 0, cnt: 2, warm: 1'b0, ov: 1'b0};
    tbl[2] = '{dd: 5, fd: 0, cnt: 3, warm: 1'b0, ov: 1'b0};
    tbl[3] = '{dd: 3, fd: 0, cnt: 4, warm: 1'b1, ov: 1'b1};
    tbl[4] = '{dd: 3, fd: 4, cnt: 5, warm: 1'b1, ov: 1'b1};
    tbl[5] = '{dd: 2, fd: 5, cnt: 6, warm: 1'b1, ov: 1'b1};

    Reset_n     = 1'b0;
    Enable      = 1'b1;
    ReadDone    = 1'b0;
    FilterReady = 1'b1;
    ov_total    = 0;
    last        = 0;
    repeat (3) step();

    check("rst_readreq", ReadReq, 0);
    check("rst_strobe", FilterStrobe, 0);
    check("rst_outvalid", OutValid, 0);
    check("rst_warm", Warm, 0);
    check("rst_count", SampleCount, 0);
    check("rst_fault", Fault, 0);

    Reset_n = 1'b1;
    rel     = cyc;

    foreach (tbl[i]) begin
      wait_req(rc);
      if (i == 0) check("first_req", rc - rel, SDIV);
      else        check("req_period", rc - last, SDIV);
      last = rc;
      serve(tbl[i].dd, tbl[i].fd, tbl[i].cnt, tbl[i].warm, tbl[i].ov);
      if (tbl[i].ov) ov_total++;
      check("ov_count", ov_count, ov_total);
    end
    check("count_after_table", SampleCount, 6);
    check("warm_after_table", Warm, 1);

    // Stray ReadDone while waiting for the tick.
    step();
    ReadDone = 1'b1;
    step();
    ReadDone = 1'b0;
    check("stray_done_strobe", FilterStrobe, 0);
    check("stray_done_count", SampleCount, 6);

    wait_req(rc);
    check("req_period_after_stray", rc - last, SDIV);
    last = rc;
    serve(3, 0, 7, 1'b1, 1'b1);
    ov_total++;
    check("ov_count_s7", ov_count, ov_total);
    exp_cnt = 7;

    wait_req(rc);
    check("req_period_s8", rc - last, SDIV);
    last = rc;
`ifdef IMU_SEQ_WATCHDOG_EN
    repeat (RTO - 1) step();
    check("fault_before_timeout", Fault, 0);
    step();
    check("fault_at_timeout", Fault, 1);
    check("count_after_timeout", SampleCount, exp_cnt);
    wait_req(rc);
    check("req_after_timeout", rc - last, SDIV);
    last = rc;
    check("fault_sticky", Fault, 1);
`else
    // Without the watchdog the read is waited on indefinitely; ticks seen
    // meanwhile are dropped, so the next request waits for a later tick.
    repeat (30) step();
    check("no_fault", Fault, 0);
    check("count_while_waiting", SampleCount, exp_cnt);
    exp_cnt++;
    serve(0, 0, exp_cnt, 1'b1, 1'b1);
    ov_total++;
    check("ov_count_late", ov_count, ov_total);
    wait_req(rc);
    check("req_after_overrun", rc - last, 3 * SDIV);
    last = rc;
`endif

    // Enable dropped one cycle after ReadReq: sample completes, then idle.
    step();
    Enable = 1'b0;
    exp_cnt++;
    serve(2, 0, exp_cnt, 1'b1, 1'b1);
    ov_total++;
    check("ov_count_disable", ov_count, ov_total);
    req_snap = req_count;
    repeat (10) step();
    ReadDone = 1'b1;
    step();
    ReadDone = 1'b0;
    repeat (30) step();
    check("no_req_when_disabled", req_count, req_snap);
    check("count_when_disabled", SampleCount, exp_cnt);

    // Re-enable from IDLE: counter was held, full period to the next request.
    Enable = 1'b1;
    last   = cyc;
    wait_req(rc);
    check("req_after_enable", rc - last, SDIV);

    // Reset in WAIT_FILT with a stale-low FilterReady.
    repeat (3) step();
    exp_cnt++;
    sb.push_back('{cnt: exp_cnt, warm: 1'b1, ov: 1'b0, gap: 3});
    ReadDone    = 1'b1;
    FilterReady = 1'b0;
    step();
    ReadDone = 1'b0;
    check("strobe_before_reset", FilterStrobe, 1);
    step();
    step();
    check("warm_before_reset", Warm, 1);
    Reset_n = 1'b0;
    #1;
    check("async_readreq", ReadReq, 0);
    check("async_strobe", FilterStrobe, 0);
    check("async_outvalid", OutValid, 0);
    check("async_warm", Warm, 0);
    check("async_count", SampleCount, 0);
    check("async_fault", Fault, 0);
    ov_snap = ov_count;
    step();
    step();
    Reset_n     = 1'b1;
    rel         = cyc;
    FilterReady = 1'b1;
    wait_req(rc);
    check("req_after_reset", rc - rel, SDIV);
    serve(3, 0, 1, 1'b0, 1'b0);
    check("no_ov_after_reset", ov_count, ov_snap);
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule

// File: doc/imu_filter_sequencer.md
IMU_FILTER_SEQUENCER -- requirements
Module: imu_filter_sequencer

Interface
REQ-001 Parameter SAMPLE_DIV, default 250000: Clock cycles per sample period (200 Hz at 50 MHz); legal range 16..2^24-1.
REQ-002 Parameter FILTER_LEN, default 200: samples needed to fill the filter before output is trusted.
REQ-003 Parameter READ_TIMEOUT, default 4096: cycles allowed between ReadReq and ReadDone.
REQ-004 Clock  input  1  single system clock; all logic on rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 Enable  input  1  level; 1 = run periodic sampling, 0 = stop after the current sample completes.
REQ-007 ReadReq  output  1  one-cycle pulse requesting an IMU accelerometer read.
REQ-008 ReadDone  input  1  one-cycle pulse from the IMU reader: new AccelX/Y/Z valid.
REQ-009 FilterStrobe  output  1  one-cycle pulse clocking one sample into the low-pass filter.
REQ-010 FilterReady  input  1  filter DataReady; high when the filtered average is valid.
REQ-011 OutValid  output  1  one-cycle pulse: filtered data is current and the filter is warm.
REQ-012 Warm  output  1  level; 1 once FILTER_LEN samples have been strobed since reset.
REQ-013 SampleCount  output  16  count of strobed samples, wraps 65535->0.
REQ-014 Fault  output  1  sticky; a read timeout occurred (only with WATCHDOG_EN).

Function
REQ-015 FSM states: IDLE, WAIT_TICK, REQUEST, WAIT_READ, STROBE, WAIT_FILT, PUBLISH.
REQ-016 Period counter runs from SAMPLE_DIV-1 down to 0 while Enable=1; at 0 it raises the tick and reloads; it holds at SAMPLE_DIV-1 while Enable=0.
REQ-017 IDLE->WAIT_TICK when Enable=1; WAIT_TICK->REQUEST on tick; WAIT_TICK->IDLE when Enable=0.
REQ-018 REQUEST asserts ReadReq for exactly one cycle, then goes to WAIT_READ.
REQ-019 WAIT_READ->STROBE on ReadDone; a ReadDone arriving in any other state is ignored.
REQ-020 STROBE asserts FilterStrobe for exactly one cycle, increments SampleCount, then goes to WAIT_FILT.
REQ-021 WAIT_FILT->PUBLISH when FilterReady=1, checked no earlier than 2 cycles after FilterStrobe so that a stale level is not accepted.
REQ-022 PUBLISH pulses OutValid for one cycle only if Warm=1, then returns to WAIT_TICK when Enable=1, else to IDLE.
REQ-023 Warm sets on the cycle SampleCount reaches FILTER_LEN (saturating internal 8+-bit counter), and clears only on reset.
REQ-024 A tick arriving while not in WAIT_TICK is counted as an overrun and dropped; no queued request.
REQ-025 Deasserting Enable mid-sample does not abort; the sample completes through PUBLISH.
REQ-026 Latency from ReadDone to FilterStrobe is exactly 1 cycle.

Reset
REQ-027 Asynchronous assertion of Reset_n=0 forces state IDLE, the period counter to SAMPLE_DIV-1, all pulse outputs to 0, Warm=0, SampleCount=0, and Fault=0.
REQ-028 Reset deassertion is synchronised internally; the FSM leaves IDLE no earlier than the second rising edge after release.
REQ-029 Reset asserted in any state discards the sample in flight; no ReadReq or FilterStrobe pulse completes.

Configuration
REQ-030 Macro IMU_SEQ_WATCHDOG_EN defined: a timeout counter runs in WAIT_READ; at READ_TIMEOUT cycles without ReadDone it sets Fault, skips STROBE, and returns to WAIT_TICK; SampleCount is unchanged.
REQ-031 Macro IMU_SEQ_WATCHDOG_EN undefined: WAIT_READ waits indefinitely, Fault is tied to 0, and no timeout logic is synthesised.

Verification
REQ-032 SAMPLE_DIV=16, Enable=1, ReadDone returned 3 cycles after each ReadReq -> ReadReq pulses exactly every 16 cycles and FilterStrobe 1 cycle after each ReadDone.
REQ-033 FILTER_LEN=4, run 6 samples with FilterReady held high -> Warm rises with the 4th strobe; OutValid fires on samples 4, 5 and 6 only; SampleCount=6.
REQ-034 Enable dropped 1 cycle after ReadReq -> that sample still strobes and publishes, the FSM reaches IDLE, and no further ReadReq follows.
REQ-035 With WATCHDOG_EN, READ_TIMEOUT=8, and ReadDone withheld -> Fault=1 at cycle 8 after ReadReq, no FilterStrobe, and the next tick issues a new ReadReq.
REQ-036 Reset_n pulsed low during WAIT_FILT -> all outputs read 0 immediately (asynchronously), SampleCount=0, and the first ReadReq occurs SAMPLE_DIV cycles after release.
REQ-037 ReadDone injected during WAIT_TICK -> ignored; no FilterStrobe and SampleCount unchanged.
